fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-slot instruction fetch stage with branch redirect and halt detection.
// Latency: one cycle from pc presented to the byte appearing in ir (ir_valid high).
// Backpressure: ir_valid/ir_ready handshake; when ir is held unconsumed, pc and ir freeze (HOLD).
//
// Ports:
//   clk, reset_n          - clock (rising edge) and asynchronous active-low reset
//   pc                    - fetch address to instruction memory (straight from the PC register)
//   instructions          - byte returned combinationally by memory for pc
//   stall                 - blocks capture of a new byte while high
//   branch_valid/_target  - one-cycle redirect; flushes ir and wins over everything else
//   ir, ir_pc, ir_valid   - captured byte, its address, and its valid flag
//   ir_ready              - decoder consumes ir this cycle when ir_valid is high
//   halted                - high while the HALT_OPCODE byte has stopped fetching
//
// Optional feature: define FETCH_RET_STACK_EN to add call_valid, ret_valid, call_target and a
// 4-entry return-address stack (priority branch > call > ret).
module fetch_unit #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] pc,
  input  logic [7:0] instructions,
  input  logic       stall,
  input  logic       branch_valid,
  input  logic [7:0] branch_target,
  output logic [7:0] ir,
  output logic [7:0] ir_pc,
  output logic       ir_valid,
  input  logic       ir_ready,
  output logic       halted
`ifdef FETCH_RET_STACK_EN
  ,
  input  logic       call_valid,
  input  logic       ret_valid,
  input  logic [7:0] call_target
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] ir_pc_q, ir_pc_d;
  logic       ir_valid_q, ir_valid_d;

  logic       slot_free;
  logic       redirect;
  logic [7:0] redirect_pc;

  assign slot_free = !ir_valid_q || ir_ready;

`ifdef FETCH_RET_STACK_EN
  // Circular buffer: pushing onto a full stack simply wraps and overwrites the oldest entry,
  // while the saturating count keeps pops from running past the surviving entries.
  logic [7:0] rs_q [4];
  logic [1:0] rs_top_q;
  logic [2:0] rs_cnt_q;
  logic       do_call;
  logic       do_ret;
  logic [1:0] push_idx;
  logic [7:0] pop_pc;

  assign do_call  = call_valid && !branch_valid;
  assign do_ret   = ret_valid && !branch_valid && !call_valid;
  assign push_idx = rs_top_q + 2'd1;
  assign pop_pc   = (rs_cnt_q == 3'd0) ? RESET_PC : rs_q[rs_top_q];

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = pc_q;
    if (branch_valid) begin
      redirect    = 1'b1;
      redirect_pc = branch_target;
    end else if (do_call) begin
      redirect    = 1'b1;
      redirect_pc = call_target;
    end else if (do_ret) begin
      redirect    = 1'b1;
      redirect_pc = pop_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        rs_q[i] <= 8'h00;
      end
      rs_top_q <= 2'd0;
      rs_cnt_q <= 3'd0;
    end else if (do_call) begin
      // Return address is the byte after the call instruction currently in ir.
      rs_q[push_idx] <= ir_pc_q + 8'd1;
      rs_top_q       <= push_idx;
      rs_cnt_q       <= (rs_cnt_q == 3'd4) ? 3'd4 : rs_cnt_q + 3'd1;
    end else if (do_ret && (rs_cnt_q != 3'd0)) begin
      rs_top_q <= rs_top_q - 2'd1;
      rs_cnt_q <= rs_cnt_q - 3'd1;
    end
  end
`else
  always_comb begin
    redirect    = branch_valid;
    redirect_pc = branch_target;
  end
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;

    if (redirect) begin
      // Flush regardless of ir_ready; the byte on instructions this cycle is dropped.
      pc_d       = redirect_pc;
      ir_valid_d = 1'b0;
      state_d    = FETCH;
    end else begin
      unique case (state_q)
        FETCH, HOLD: begin
          if (slot_free) begin
            if (!stall) begin
              ir_d       = instructions;
              ir_pc_d    = pc_q;
              ir_valid_d = 1'b1;
              pc_d       = pc_q + 8'd1;
              state_d    = (instructions == HALT_OPCODE) ? HALT : FETCH;
            end else begin
              // Slot is free, so whatever ir held is either consumed now or was never valid.
              ir_valid_d = 1'b0;
              state_d    = FETCH;
            end
          end else begin
            state_d = HOLD;
          end
        end
        HALT: begin
          // Halt byte stays presented until the decoder takes it; no further captures.
          if (ir_ready) begin
            ir_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= 8'h00;
      ir_pc_q    <= 8'h00;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign pc       = pc_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;
  assign halted   = (state_q == HALT);

endmodule
